// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and optional skid entry
// PIPE_STAGE_PERF_EN enables the stall/flush performance counters.
module pipe_stage_reg #(
  parameter int DWIDTH = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] main_q, main_d;
  logic [DWIDTH-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, consume;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  // Skid build: in_ready comes straight from a flop, so out_ready never reaches it.
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept && consume) begin
          main_d = in_data;
        end else if (accept && (SKID != 0)) begin
          skid_d  = in_data;
          state_d = ST_SKID;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops valid state only; payload keeps its old contents.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // a: SKID=1 DWIDTH=32; b: SKID=0; c: SKID=1 with 4-bit counters
  logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [31:0] in_data_a, out_data_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;

  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [31:0] in_data_b, out_data_b;
  logic [15:0] stall_cnt_b, flush_cnt_b;

  logic        flush_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [7:0]  in_data_c, out_data_c;
  logic [3:0]  stall_cnt_c, flush_cnt_c;

  pipe_stage_reg #(.DWIDTH(32), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_stage_reg #(.DWIDTH(32), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  pipe_stage_reg #(.DWIDTH(8), .SKID(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .flush(flush_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_data(in_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
    .stall_cnt(stall_cnt_c), .flush_cnt(flush_cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_data_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_a got v=%b r=%b d=%h exp v=0 r=1 d=0", out_valid_a, in_ready_a, out_data_a);
    end
    checks++;
    if (stall_cnt_a !== 16'h0 || flush_cnt_a !== 16'h0 || stall_cnt_c !== 4'h0) begin
      errors++;
      $display("FAIL reset_cnt got s=%h f=%h sc=%h exp 0", stall_cnt_a, flush_cnt_a, stall_cnt_c);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1 || out_valid_c !== 1'b0 || in_ready_c !== 1'b1) begin
      errors++;
      $display("FAIL reset_bc got vb=%b rb=%b vc=%b rc=%b exp 0 1 0 1", out_valid_b, in_ready_b, out_valid_c, in_ready_c);
    end
  endtask

  task automatic test_streaming();
    out_ready_a = 1'b1;
    in_valid_a  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data_a = 32'(i);
      step();
      checks++;
      if (out_valid_a !== 1'b1 || out_data_a !== 32'(i) || in_ready_a !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d got v=%b d=%h r=%b exp v=1 d=%h r=1", i, out_valid_a, out_data_a, in_ready_a, i);
      end
    end
    in_valid_a = 1'b0;
    step();
    checks++;
    if (out_valid_a !== 1'b0 || stall_cnt_a !== 16'h0) begin
      errors++;
      $display("FAIL stream_drain got v=%b s=%h exp v=0 s=0", out_valid_a, stall_cnt_a);
    end
  endtask

  task automatic test_backpressure();
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    in_data_a   = 32'hA;
    step();
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 32'hA || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_full got v=%b d=%h r=%b exp v=1 d=a r=1", out_valid_a, out_data_a, in_ready_a);
    end
    in_data_a = 32'hB;
    step();
    in_valid_a = 1'b0;
    checks++;
    if (in_ready_a !== 1'b0 || out_data_a !== 32'hA || out_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_skid got r=%b d=%h v=%b exp r=0 d=a v=1", in_ready_a, out_data_a, out_valid_a);
    end
    step();
    checks++;
    if (out_data_a !== 32'hA || in_ready_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got d=%h r=%b exp d=a r=0", out_data_a, in_ready_a);
    end
    out_ready_a = 1'b1;
    step();
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 32'hB || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_second got v=%b d=%h r=%b exp v=1 d=b r=1", out_valid_a, out_data_a, in_ready_a);
    end
    step();
    checks++;
    if (out_valid_a !== 1'b0 || stall_cnt_a !== (PERF ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL bp_done got v=%b s=%0d exp v=0 s=%0d", out_valid_a, stall_cnt_a, PERF ? 2 : 0);
    end
  endtask

  task automatic test_flush();
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    in_data_a   = 32'h11;
    step();
    in_data_a = 32'h22;
    step();
    flush_a   = 1'b1;
    in_data_a = 32'h33;
    step();
    flush_a     = 1'b0;
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_data_a !== 32'h11) begin
      errors++;
      $display("FAIL flush_kill got v=%b r=%b d=%h exp v=0 r=1 d=11", out_valid_a, in_ready_a, out_data_a);
    end
    checks++;
    if (flush_cnt_a !== (PERF ? 16'd1 : 16'd0) || stall_cnt_a !== (PERF ? 16'd3 : 16'd0)) begin
      errors++;
      $display("FAIL flush_cnt got f=%0d s=%0d exp f=%0d s=%0d", flush_cnt_a, stall_cnt_a, PERF ? 1 : 0, PERF ? 3 : 0);
    end
    step();
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL flush_no33 got v=%b d=%h exp v=0", out_valid_a, out_data_a);
    end
    in_valid_a = 1'b1;
    in_data_a  = 32'h44;
    step();
    in_valid_a = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 32'h44) begin
      errors++;
      $display("FAIL flush_resume got v=%b d=%h exp v=1 d=44", out_valid_a, out_data_a);
    end
    step();
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    checks++;
    if (flush_cnt_a !== (PERF ? 16'd1 : 16'd0) || out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty got f=%0d v=%b exp f=%0d v=0", flush_cnt_a, out_valid_a, PERF ? 1 : 0);
    end
  endtask

  task automatic test_skid0();
    out_ready_b = 1'b0;
    in_valid_b  = 1'b1;
    in_data_b   = 32'h5;
    #1;
    checks++;
    if (in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL s0_empty_ready got r=%b exp 1", in_ready_b);
    end
    step();
    checks++;
    if (in_ready_b !== 1'b0 || out_valid_b !== 1'b1 || out_data_b !== 32'h5) begin
      errors++;
      $display("FAIL s0_full got r=%b v=%b d=%h exp r=0 v=1 d=5", in_ready_b, out_valid_b, out_data_b);
    end
    in_data_b = 32'h6;
    step();
    checks++;
    if (out_data_b !== 32'h5) begin
      errors++;
      $display("FAIL s0_hold got d=%h exp 5", out_data_b);
    end
    out_ready_b = 1'b1;
    #1;
    checks++;
    if (in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL s0_comb_ready got r=%b exp 1", in_ready_b);
    end
    step();
    in_valid_b = 1'b0;
    checks++;
    if (out_valid_b !== 1'b1 || out_data_b !== 32'h6) begin
      errors++;
      $display("FAIL s0_replace got v=%b d=%h exp v=1 d=6", out_valid_b, out_data_b);
    end
    step();
    checks++;
    if (out_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL s0_drain got v=%b exp 0", out_valid_b);
    end
  endtask

  task automatic test_saturation();
    out_ready_c = 1'b0;
    in_valid_c  = 1'b1;
    in_data_c   = 8'h7;
    step();
    in_valid_c = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) begin
        checks++;
        if (stall_cnt_c !== (PERF ? 4'd10 : 4'd0)) begin
          errors++;
          $display("FAIL sat_mid got s=%0d exp %0d", stall_cnt_c, PERF ? 10 : 0);
        end
      end
    end
    checks++;
    if (stall_cnt_c !== (PERF ? 4'd15 : 4'd0) || flush_cnt_c !== 4'd0 || out_data_c !== 8'h7) begin
      errors++;
      $display("FAIL sat_end got s=%0d f=%0d d=%h exp s=%0d f=0 d=07", stall_cnt_c, flush_cnt_c, out_data_c, PERF ? 15 : 0);
    end
    out_ready_c = 1'b1;
    step();
    checks++;
    if (out_valid_c !== 1'b0 || stall_cnt_c !== (PERF ? 4'd15 : 4'd0)) begin
      errors++;
      $display("FAIL sat_drain got v=%b s=%0d exp v=0 s=%0d", out_valid_c, stall_cnt_c, PERF ? 15 : 0);
    end
  endtask

  task automatic test_reset_mid();
    out_ready_a = 1'b0;
    in_valid_a  = 1'b1;
    in_data_a   = 32'h55;
    step();
    in_data_a = 32'h66;
    step();
    in_valid_a = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_data_a !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_a got v=%b r=%b d=%h exp v=0 r=1 d=0", out_valid_a, in_ready_a, out_data_a);
    end
    checks++;
    if (stall_cnt_a !== 16'h0 || flush_cnt_a !== 16'h0 || stall_cnt_c !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_cnt got s=%h f=%h sc=%h exp 0", stall_cnt_a, flush_cnt_a, stall_cnt_c);
    end
    out_ready_a = 1'b1;
    #1;
    rst = 1'b0;
    in_valid_a = 1'b1;
    in_data_a  = 32'h77;
    step();
    in_valid_a = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || out_data_a !== 32'h77) begin
      errors++;
      $display("FAIL rstmid_resume got v=%b d=%h exp v=1 d=77", out_valid_a, out_data_a);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0;
    flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
    flush_c = 1'b0; in_valid_c = 1'b0; out_ready_c = 1'b0; in_data_c = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
